// File: rtl/data_mem_if.sv
// -----------------------------------------------------------------------------
// data_mem_if
// Bundles the MEM-stage request/response signals between the CPU pipeline and
// the data memory responder.
//   master modport (pipeline): drives req_read, req_write, req_addr, req_wdata,
//                              req_be; receives rdata, stall, resp_valid,
//                              addr_err.
//   slave modport  (memory)  : the mirror image.
// -----------------------------------------------------------------------------
interface data_mem_if;
    logic        req_read;
    logic        req_write;
    logic [31:0] req_addr;
    logic [31:0] req_wdata;
    logic [3:0]  req_be;
    logic [31:0] rdata;
    logic        stall;
    logic        resp_valid;
    logic        addr_err;

    modport master (
        output req_read, req_write, req_addr, req_wdata, req_be,
        input  rdata, stall, resp_valid, addr_err
    );

    modport slave (
        input  req_read, req_write, req_addr, req_wdata, req_be,
        output rdata, stall, resp_valid, addr_err
    );
endinterface

// File: rtl/data_mem_responder.sv
// -----------------------------------------------------------------------------
// data_mem_responder
// MEM-stage data memory with a fixed multi-cycle load latency. Stores commit in
// a single cycle without stalling; loads freeze the pipeline for WAIT_STATES
// cycles and then present registered read data with a one-cycle resp_valid.
// Misaligned, out-of-range or ambiguous (read and write both high) requests
// are rejected with a one-cycle registered addr_err pulse.
//
// Ports
//   clk      : clock, rising edge
//   rst      : synchronous active-high reset (array contents are preserved)
//   mem_bus  : data_mem_if.slave - req_read/req_write/req_addr/req_wdata/req_be
//              in, rdata/stall/resp_valid/addr_err out
//
// Parameters
//   DEPTH_WORDS : number of 32-bit words (power of two, 16..4096)
//   WAIT_STATES : load latency in stall cycles (1..15)
//
// Build option
//   MEM_BYTE_WRITE_EN : when defined, stores write only bytes enabled by
//                       req_be (req_be==0 is a legal no-op store); when
//                       undefined, req_be is ignored and stores write all
//                       32 bits.
// -----------------------------------------------------------------------------
module data_mem_responder #(
    parameter int DEPTH_WORDS = 256,
    parameter int WAIT_STATES = 2
) (
    input  logic       clk,
    input  logic       rst,
    data_mem_if.slave  mem_bus
);
    localparam int AW = $clog2(DEPTH_WORDS);

    typedef enum logic [1:0] {
        S_IDLE = 2'd0,
        S_WAIT = 2'd1,
        S_DONE = 2'd2
    } state_t;

    state_t          state_q, state_d;
    logic [3:0]      cnt_q, cnt_d;
    logic [AW-1:0]   addr_q, addr_d;
    logic [31:0]     rdata_q;
    logic            addr_err_q;

    logic [31:0]     mem_array [DEPTH_WORDS];

    // Request decode
    logic            aligned, in_range, one_op, req_any, legal;
    logic            legal_load, legal_store, idle;
    logic [AW-1:0]   req_idx;
    logic [3:0]      be_eff;

    // Output-process results
    logic            stall_o, resp_valid_o;
    logic            rd_en, wr_en;
    logic [AW-1:0]   rd_idx;

    assign idle        = (state_q == S_IDLE);
    assign aligned     = (mem_bus.req_addr[1:0] == 2'b00);
    assign in_range    = (mem_bus.req_addr[31:AW+2] == '0);
    assign one_op      = mem_bus.req_read ^ mem_bus.req_write;
    assign req_any     = mem_bus.req_read | mem_bus.req_write;
    assign legal       = aligned & in_range & one_op;
    assign legal_load  = legal & mem_bus.req_read;
    assign legal_store = legal & mem_bus.req_write;
    assign req_idx     = mem_bus.req_addr[AW+1:2];

`ifdef MEM_BYTE_WRITE_EN
    assign be_eff = mem_bus.req_be;
`else
    assign be_eff = 4'hF;
`endif

    // State register
    always_ff @(posedge clk) begin
        if (rst) begin
            state_q <= S_IDLE;
            cnt_q   <= 4'd0;
            addr_q  <= '0;
        end else begin
            state_q <= state_d;
            cnt_q   <= cnt_d;
            addr_q  <= addr_d;
        end
    end

    // Next-state logic. The counter is loaded with WAIT_STATES-1 and the FSM
    // leaves WAIT on the edge where it decrements to zero, so WAIT lasts
    // WAIT_STATES-1 cycles and the total stall window (IDLE cycle + WAIT)
    // is exactly WAIT_STATES cycles.
    always_comb begin
        state_d = state_q;
        cnt_d   = cnt_q;
        addr_d  = addr_q;
        case (state_q)
            S_IDLE: begin
                if (legal_load) begin
                    addr_d  = req_idx;
                    cnt_d   = 4'(WAIT_STATES - 1);
                    state_d = (WAIT_STATES == 1) ? S_DONE : S_WAIT;
                end
            end
            S_WAIT: begin
                cnt_d = cnt_q - 4'd1;
                if (cnt_q == 4'd1) begin
                    state_d = S_DONE;
                end
            end
            S_DONE: begin
                state_d = S_IDLE;
            end
            default: begin
                state_d = S_IDLE;
            end
        endcase
    end

    // Output logic. In IDLE the stall is combinational on the incoming load so
    // the pipeline freezes in the same cycle the load is presented.
    always_comb begin
        stall_o      = 1'b0;
        resp_valid_o = 1'b0;
        rd_en        = 1'b0;
        wr_en        = 1'b0;
        rd_idx       = addr_q;
        case (state_q)
            S_IDLE: begin
                stall_o = legal_load;
                wr_en   = legal_store & ~rst;
                rd_idx  = req_idx;
                rd_en   = legal_load & (WAIT_STATES == 1);
            end
            S_WAIT: begin
                stall_o = 1'b1;
                rd_en   = (cnt_q == 4'd1);
            end
            S_DONE: begin
                resp_valid_o = 1'b1;
            end
            default: begin
                stall_o = 1'b0;
            end
        endcase
    end

    // Array write port; contents deliberately survive reset.
    always_ff @(posedge clk) begin
        if (wr_en) begin
            for (int b = 0; b < 4; b++) begin
                if (be_eff[b]) begin
                    mem_array[req_idx][8*b +: 8] <= mem_bus.req_wdata[8*b +: 8];
                end
            end
        end
    end

    // Registered array read; rdata holds until the next load completes.
    always_ff @(posedge clk) begin
        if (rst) begin
            rdata_q <= 32'd0;
        end else if (rd_en) begin
            rdata_q <= mem_array[rd_idx];
        end
    end

    // Rejected request: any read/write activity in IDLE that is not legal.
    always_ff @(posedge clk) begin
        if (rst) begin
            addr_err_q <= 1'b0;
        end else begin
            addr_err_q <= idle & req_any & ~legal;
        end
    end

    assign mem_bus.rdata      = rdata_q;
    assign mem_bus.stall      = stall_o;
    assign mem_bus.resp_valid = resp_valid_o;
    assign mem_bus.addr_err   = addr_err_q;
endmodule

// File: doc/data_mem_responder.md
DATA_MEM_RESPONDER -- requirements
Module: data_mem_responder

Interface
REQ-001 Parameter DEPTH_WORDS, default 256, number of 32-bit words in the data array (power of two, 16..4096).
REQ-002 Parameter WAIT_STATES, default 2, read latency in stall cycles (1..15).
REQ-003 clk  input  1  clock; all state updates on its rising edge.
REQ-004 rst  input  1  reset, synchronous, active-high.
REQ-005 req_read  input  1  MEM-stage load request.
REQ-006 req_write  input  1  MEM-stage store request.
REQ-007 req_addr  input  32  byte address of the request.
REQ-008 req_wdata  input  32  store data.
REQ-009 req_be  input  4  byte enables, bit i = byte i (bits 7+8i:8i).
REQ-010 rdata  output  32  load data, registered.
REQ-011 stall  output  1  pipeline freeze request, combinational.
REQ-012 resp_valid  output  1  one-cycle pulse marking rdata valid for the current load.
REQ-013 addr_err  output  1  one-cycle registered pulse flagging a rejected request.

Function
REQ-014 The request SHALL be legal only when req_addr[1:0]==0, req_addr < 4*DEPTH_WORDS, and exactly one of req_read/req_write is high.
REQ-015 The FSM SHALL have states IDLE, WAIT, DONE; requests SHALL be sampled only in IDLE.
REQ-016 IDLE + legal store in cycle T: write committed at the edge ending T, no stall, no resp_valid, stay IDLE.
REQ-017 IDLE + legal load in cycle T: capture address, load counter with WAIT_STATES-1, go to WAIT (or DONE if WAIT_STATES==1).
REQ-018 stall SHALL be high in cycles T..T+WAIT_STATES-1 (combinational on req_read in IDLE, registered in WAIT), low otherwise.
REQ-019 WAIT SHALL decrement the counter each cycle and go to DONE at the edge where it is zero; the array read SHALL occur at that edge into rdata.
REQ-020 DONE (cycle T+WAIT_STATES): resp_valid high, stall low, rdata valid; next edge returns to IDLE; request inputs ignored in DONE.
REQ-021 The pipeline SHALL hold req_* stable while stall is high; the block SHALL use only captured values after T.
REQ-022 Illegal request in IDLE: no array access, no stall, addr_err high in cycle T+1 only, stay IDLE.
REQ-023 rdata SHALL hold its last loaded value until the next load completes.
REQ-024 A store to an address captured by a pending load is impossible (stall holds pipeline); no hazard logic required.

Reset
REQ-025 rst high at any edge SHALL force IDLE, counter 0, rdata 0, resp_valid 0, addr_err 0; stall SHALL read 0 in the cycle after reset unless a new IDLE load is presented.
REQ-026 Reset mid-load SHALL abandon the load with no resp_valid; array contents SHALL NOT be cleared by reset.

Configuration
REQ-027 With MEM_BYTE_WRITE_EN defined, stores SHALL write only the bytes whose req_be bit is 1; req_be==0 SHALL be a legal no-op store.
REQ-028 Without MEM_BYTE_WRITE_EN, req_be SHALL be ignored and every store SHALL write all 32 bits.

Verification
REQ-029 Reset, store 0xDEADBEEF to 0x10, load 0x10 (WAIT_STATES=2) -> stall high 2 cycles, resp_valid and rdata=0xDEADBEEF in cycle 3 only.
REQ-030 Load from 0x13 -> no stall, addr_err high exactly one cycle after, rdata unchanged.
REQ-031 req_read and req_write both high at 0x20 -> addr_err pulse, word 0x20 unchanged on later load.
REQ-032 With MEM_BYTE_WRITE_EN: word 0x40=0x11223344, store 0xAABBCCDD be=4'b0101 -> load returns 0x11BB33DD; without macro -> 0xAABBCCDD.
REQ-033 rst asserted in WAIT of a load -> resp_valid never pulses, stall 0, rdata 0; previously stored words still readable.
REQ-034 Back-to-back loads 0x0 then 0x4 -> second load sampled in cycle after DONE, each with its own full stall window and single resp_valid.
